rdb_data_sel_pipe: RTL and testbench

- Parametrised, registered successor of the read-data-buffer channel selector.
- Per direction and per hash group, it picks one of CH_PER_GRP channel payloads and buffers it in a per-lane FIFO.
- The read-data-buffer (RDB) and evict-data-buffer (EVDB) drain the lanes with valid/ready.
- The EVICT_DIR direction is split by opcode into a read lane and an evict lane; protocol violations are recorded in sticky error flags instead of being asserted.

---
 rtl/vector_cache_pkg.sv | 13 +
 rtl/rdb_sel_lane_fifo.sv | 40 ++++
 rtl/rdb_data_sel_pipe.sv | 84 ++++++++
 tb/tb_rdb_data_sel_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vector_cache_pkg.sv
// vector_cache_pkg: shared payload type, opcodes and default geometry for the vector cache data path.
package vector_cache_pkg;
   typedef struct packed {
      logic [1:0]  opcode;
      logic [7:0]  tag;
      logic [31:0] data;
   } group_data_pld_t;
   localparam logic [1:0] OPC_READ  = 2'd1;
   localparam logic [1:0] OPC_EVICT = 2'd2;
   localparam int DIR_NUM_DEF    = 4;
   localparam int GRP_NUM_DEF    = 4;
   localparam int CH_PER_GRP_DEF = 2;
endpackage

// File: rtl/rdb_sel_lane_fifo.sv
// rdb_sel_lane_fifo: registered per-lane FIFO; a push when full is dropped unless the head pops in the same cycle.
module rdb_sel_lane_fifo #(
   parameter int  DEPTH = 2,
   parameter type pld_t = logic [7:0]
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  pld_t push_pld,
   output logic full,
   output logic vld,
   output pld_t pld,
   input  logic rdy,
   output logic ovf
);
   localparam int AW = $clog2(DEPTH);
   pld_t          mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   cnt;
   logic          pop, acc;
   assign full = cnt == (AW+1)'(DEPTH);
   assign vld  = cnt != '0;
   assign pld  = mem[rd_ptr];
   assign pop  = vld && rdy;
   assign acc  = push && (!full || pop);
   assign ovf  = push && full && !pop;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (acc) wr_ptr <= wr_ptr + 1'b1;
         cnt <= cnt + (AW+1)'(acc) - (AW+1)'(pop);
      end
   // storage needs no reset: the head is only observed while vld is high
   always_ff @(posedge clk)
      if (acc) mem[wr_ptr] <= push_pld;
endmodule

// File: rtl/rdb_data_sel_pipe.sv
// rdb_data_sel_pipe: per-group lowest-index channel select, opcode routing into read/evict lane FIFOs,
// sticky protocol errors and a saturating drop counter.
module rdb_data_sel_pipe import vector_cache_pkg::*; #(
   parameter int DIR_NUM    = DIR_NUM_DEF,
   parameter int GRP_NUM    = GRP_NUM_DEF,
   parameter int CH_PER_GRP = CH_PER_GRP_DEF,
   parameter int FIFO_DEPTH = 2,
   parameter int EVICT_DIR  = 2,
   parameter int CNT_W      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic [DIR_NUM-1:0][GRP_NUM*CH_PER_GRP-1:0] in_vld,
   input  group_data_pld_t [DIR_NUM-1:0][GRP_NUM*CH_PER_GRP-1:0] in_pld,
   output logic [DIR_NUM-1:0][GRP_NUM-1:0] rdb_vld,
   output group_data_pld_t [DIR_NUM-1:0][GRP_NUM-1:0] rdb_pld,
   input  logic [DIR_NUM-1:0][GRP_NUM-1:0] rdb_rdy,
   output logic [GRP_NUM-1:0] evdb_vld,
   output group_data_pld_t [GRP_NUM-1:0] evdb_pld,
   input  logic [GRP_NUM-1:0] evdb_rdy,
   input  logic err_clr,
   output logic [DIR_NUM-1:0] err_conflict,
   output logic err_ovf,
   output logic err_opcode,
   output logic [CNT_W-1:0] drop_cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic [DIR_NUM-1:0][GRP_NUM-1:0] conf, bad, rd_ovf, rd_full;
   logic [GRP_NUM-1:0]              ev_ovf, ev_full;
   logic [DIR_NUM-1:0]              conf_dir;
   logic [31:0]                     loss [DIR_NUM][GRP_NUM];
   logic [31:0]                     inc;
   logic [63:0]                     cnt_sum;
   logic [CNT_W-1:0]                drop_nxt;
   for (genvar d = 0; d < DIR_NUM; d++) begin : g_dir
      assign conf_dir[d] = |conf[d];
      for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp
         logic [CH_PER_GRP-1:0] v;
         group_data_pld_t       win;
         logic                  win_vld, is_rd, is_ev;
         assign v = in_vld[d][g*CH_PER_GRP +: CH_PER_GRP];
         always_comb begin
            win = '0;
            for (int c = CH_PER_GRP-1; c >= 0; c--)
               if (v[c]) win = in_pld[d][g*CH_PER_GRP+c];
         end
         assign win_vld    = |v;
         assign is_ev      = win_vld && d == EVICT_DIR && win.opcode == OPC_EVICT;
         assign is_rd      = win_vld && (d != EVICT_DIR || win.opcode == OPC_READ);
         assign bad[d][g]  = win_vld && !is_ev && !is_rd;
         assign conf[d][g] = $countones(v) > 1;
         assign loss[d][g] = win_vld ? 32'($countones(v) - 1) : 32'd0;
         rdb_sel_lane_fifo #(.DEPTH(FIFO_DEPTH), .pld_t(group_data_pld_t)) u_rd (
            .clk(clk), .rst_n(rst_n), .push(is_rd), .push_pld(win), .full(rd_full[d][g]),
            .vld(rdb_vld[d][g]), .pld(rdb_pld[d][g]), .rdy(rdb_rdy[d][g]), .ovf(rd_ovf[d][g]));
         if (d == EVICT_DIR) begin : g_ev
            rdb_sel_lane_fifo #(.DEPTH(FIFO_DEPTH), .pld_t(group_data_pld_t)) u_ev (
               .clk(clk), .rst_n(rst_n), .push(is_ev), .push_pld(win), .full(ev_full[g]),
               .vld(evdb_vld[g]), .pld(evdb_pld[g]), .rdy(evdb_rdy[g]), .ovf(ev_ovf[g]));
         end
      end
   end
   // every drop source of the cycle lands in one increment so clear and saturation see the full total
   always_comb begin
      inc = 32'($countones(bad)) + 32'($countones(rd_ovf)) + 32'($countones(ev_ovf));
      for (int d = 0; d < DIR_NUM; d++)
         for (int g = 0; g < GRP_NUM; g++)
            inc = inc + loss[d][g];
      cnt_sum  = 64'(err_clr ? '0 : drop_cnt) + 64'(inc);
      drop_nxt = cnt_sum > 64'(CNT_MAX) ? CNT_MAX : cnt_sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         err_conflict <= '0;
         err_ovf      <= 1'b0;
         err_opcode   <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         err_conflict <= (err_clr ? '0 : err_conflict) | conf_dir;
         err_ovf      <= (err_ovf && !err_clr) || |rd_ovf || |ev_ovf;
         err_opcode   <= (err_opcode && !err_clr) || |bad;
         drop_cnt     <= drop_nxt;
      end
endmodule

// File: tb/tb_rdb_data_sel_pipe.sv
// tb_rdb_data_sel_pipe: directed plus randomized checks against a queue-based lane model.
module tb_rdb_data_sel_pipe;
   import vector_cache_pkg::*;
   localparam int DN = 4, GN = 4, CN = 2, NCH = GN*CN, DEPTH = 2, EV = 2, CW = 3;
   localparam int CMAX = (1 << CW) - 1;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [DN-1:0][NCH-1:0] in_vld;
   group_data_pld_t [DN-1:0][NCH-1:0] in_pld;
   logic [DN-1:0][GN-1:0] rdb_vld, rdb_rdy;
   group_data_pld_t [DN-1:0][GN-1:0] rdb_pld;
   logic [GN-1:0] evdb_vld, evdb_rdy;
   group_data_pld_t [GN-1:0] evdb_pld;
   logic err_clr, err_ovf, err_opcode;
   logic [DN-1:0] err_conflict;
   logic [CW-1:0] drop_cnt;
   group_data_pld_t rq [DN*GN][$];
   group_data_pld_t eq [GN][$];
   logic [DN-1:0] m_conf;
   bit m_ovf, m_opc;
   int m_cnt;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   rdb_data_sel_pipe #(.DIR_NUM(DN), .GRP_NUM(GN), .CH_PER_GRP(CN), .FIFO_DEPTH(DEPTH),
      .EVICT_DIR(EV), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_pld(in_pld), .rdb_vld(rdb_vld),
      .rdb_pld(rdb_pld), .rdb_rdy(rdb_rdy), .evdb_vld(evdb_vld), .evdb_pld(evdb_pld),
      .evdb_rdy(evdb_rdy), .err_clr(err_clr), .err_conflict(err_conflict), .err_ovf(err_ovf),
      .err_opcode(err_opcode), .drop_cnt(drop_cnt));
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < DN*GN; i++) rq[i].delete();
      for (int g = 0; g < GN; g++) eq[g].delete();
      m_conf = '0; m_ovf = 0; m_opc = 0; m_cnt = 0;
   endtask
   task automatic model_step();
      int inc = 0;
      logic [DN-1:0] n_conf = '0;
      bit n_ovf = 0, n_opc = 0;
      bit rpu [DN*GN];
      bit epu [GN];
      group_data_pld_t rp [DN*GN];
      group_data_pld_t ep [GN];
      for (int i = 0; i < DN*GN; i++) begin rpu[i] = 0; rp[i] = '0; end
      for (int g = 0; g < GN; g++) begin epu[g] = 0; ep[g] = '0; end
      for (int d = 0; d < DN; d++)
         for (int g = 0; g < GN; g++) begin
            int n = 0;
            group_data_pld_t w = '0;
            for (int c = 0; c < CN; c++)
               if (in_vld[d][g*CN+c]) begin
                  if (n == 0) w = in_pld[d][g*CN+c];
                  n++;
               end
            if (n > 1) begin n_conf[d] = 1'b1; inc += n - 1; end
            if (n > 0) begin
               if (d != EV || w.opcode == 2'd1) begin rpu[d*GN+g] = 1; rp[d*GN+g] = w; end
               else if (w.opcode == 2'd2) begin epu[g] = 1; ep[g] = w; end
               else begin n_opc = 1; inc++; end
            end
         end
      for (int i = 0; i < DN*GN; i++) begin
         if (rq[i].size() > 0 && rdb_rdy[i/GN][i%GN]) void'(rq[i].pop_front());
         if (rpu[i]) begin
            if (rq[i].size() < DEPTH) rq[i].push_back(rp[i]);
            else begin n_ovf = 1; inc++; end
         end
      end
      for (int g = 0; g < GN; g++) begin
         if (eq[g].size() > 0 && evdb_rdy[g]) void'(eq[g].pop_front());
         if (epu[g]) begin
            if (eq[g].size() < DEPTH) eq[g].push_back(ep[g]);
            else begin n_ovf = 1; inc++; end
         end
      end
      m_conf = (err_clr ? '0 : m_conf) | n_conf;
      m_ovf  = (m_ovf && !err_clr) || n_ovf;
      m_opc  = (m_opc && !err_clr) || n_opc;
      m_cnt  = (err_clr ? 0 : m_cnt) + inc;
      if (m_cnt > CMAX) m_cnt = CMAX;
   endtask
   task automatic check_all();
      for (int i = 0; i < DN*GN; i++) begin
         chk($sformatf("rdb_vld[%0d][%0d]", i/GN, i%GN), rdb_vld[i/GN][i%GN], rq[i].size() != 0);
         if (rq[i].size() != 0)
            chk($sformatf("rdb_pld[%0d][%0d]", i/GN, i%GN), rdb_pld[i/GN][i%GN], rq[i][0]);
      end
      for (int g = 0; g < GN; g++) begin
         chk($sformatf("evdb_vld[%0d]", g), evdb_vld[g], eq[g].size() != 0);
         if (eq[g].size() != 0) chk($sformatf("evdb_pld[%0d]", g), evdb_pld[g], eq[g][0]);
      end
      chk("err_conflict", err_conflict, m_conf);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_opcode", err_opcode, m_opc);
      chk("drop_cnt", drop_cnt, m_cnt);
   endtask
   task automatic step();
      model_step();
      @(negedge clk);
      check_all();
   endtask
   task automatic idle();
      in_vld = '0;
      err_clr = 1'b0;
   endtask
   task automatic beat(input int d, input int ch, input logic [1:0] opc, input logic [7:0] tag,
                       input logic [31:0] data);
      in_vld[d][ch] = 1'b1;
      in_pld[d][ch] = group_data_pld_t'({opc, tag, data});
   endtask
   task automatic clear_errs();
      idle();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
   endtask
   task automatic rand_inputs(input bit rdy_rand);
      for (int d = 0; d < DN; d++)
         for (int ch = 0; ch < NCH; ch++) begin
            int r = $urandom_range(0, 9);
            logic [1:0] opc = r == 0 ? 2'd0 : r == 1 ? 2'd3 : r < 6 ? 2'd1 : 2'd2;
            in_vld[d][ch] = $urandom_range(0, 5) == 0;
            in_pld[d][ch] = group_data_pld_t'({opc, 8'($urandom), 32'($urandom)});
         end
      for (int d = 0; d < DN; d++)
         for (int g = 0; g < GN; g++) rdb_rdy[d][g] = rdy_rand && $urandom_range(0, 3) != 0;
      for (int g = 0; g < GN; g++) evdb_rdy[g] = rdy_rand && $urandom_range(0, 3) != 0;
      err_clr = $urandom_range(0, 40) == 0;
   endtask
   initial begin
      in_vld = '0; in_pld = '0; rdb_rdy = '1; evdb_rdy = '1; err_clr = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_all();
      chk("reset_drop", drop_cnt, 0);
      // single beat east ch5 -> lane [0][2]
      idle(); beat(0, 5, 2'd1, 8'h55, 32'hA5A5_0005);
      step();
      chk("t1_vld", rdb_vld[0][2], 1);
      chk("t1_pld", rdb_pld[0][2], {2'd1, 8'h55, 32'hA5A5_0005});
      idle(); step();
      chk("t1_gone", rdb_vld[0][2], 0);
      chk("t1_drop", drop_cnt, 0);
      // conflict on west grp0
      idle(); beat(1, 0, 2'd1, 8'h10, 32'h1000_0000); beat(1, 1, 2'd1, 8'h11, 32'h1100_0000);
      step();
      chk("t2_pld", rdb_pld[1][0], {2'd1, 8'h10, 32'h1000_0000});
      chk("t2_conf", err_conflict[1], 1);
      chk("t2_drop", drop_cnt, 1);
      clear_errs();
      chk("t2_conf_clr", err_conflict, 0);
      chk("t2_drop_clr", drop_cnt, 0);
      // evict split on south grp1
      idle(); beat(2, 2, 2'd2, 8'hE0, 32'hE000_0001);
      step();
      chk("t3_ev_vld", evdb_vld[1], 1);
      chk("t3_ev_pld", evdb_pld[1], {2'd2, 8'hE0, 32'hE000_0001});
      chk("t3_rd_quiet", rdb_vld[2][1], 0);
      idle(); beat(2, 2, 2'd1, 8'hE1, 32'hE000_0002);
      step();
      chk("t3_rd_vld", rdb_vld[2][1], 1);
      chk("t3_rd_pld", rdb_pld[2][1], {2'd1, 8'hE1, 32'hE000_0002});
      chk("t3_ev_quiet", evdb_vld[1], 0);
      // bad opcode on south
      idle(); beat(2, 0, 2'd3, 8'hBD, 32'h0BAD_0BAD);
      step();
      chk("t4_rd_none", rdb_vld[2], 0);
      chk("t4_ev_none", evdb_vld, 0);
      chk("t4_opc", err_opcode, 1);
      chk("t4_drop", drop_cnt, 1);
      clear_errs();
      // overflow on north grp0
      rdb_rdy[3][0] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         idle(); beat(3, 0, 2'd1, 8'h30 + 8'(k), 32'(k));
         step();
      end
      chk("t5_head", rdb_pld[3][0], {2'd1, 8'h30, 32'd0});
      chk("t5_ovf", err_ovf, 1);
      chk("t5_drop", drop_cnt, 1);
      idle(); beat(3, 0, 2'd1, 8'h33, 32'd3); rdb_rdy[3][0] = 1'b1;
      step();
      chk("t5_head2", rdb_pld[3][0], {2'd1, 8'h31, 32'd1});
      idle(); step();
      chk("t5_head3", rdb_pld[3][0], {2'd1, 8'h33, 32'd3});
      idle(); step();
      chk("t5_empty", rdb_vld[3][0], 0);
      clear_errs();
      // saturation: 4 losers per cycle for 3 cycles
      for (int k = 0; k < 3; k++) begin
         idle();
         for (int ch = 0; ch < NCH; ch++) beat(1, ch, 2'd1, 8'(ch), 32'(k));
         step();
      end
      chk("t6_sat", drop_cnt, CMAX);
      clear_errs();
      // reset with lanes backed up
      for (int k = 0; k < 3; k++) begin
         rand_inputs(1'b0);
         err_clr = 1'b0;
         step();
      end
      rst_n = 1'b0;
      #1;
      chk("t7_rdb_vld", rdb_vld, 0);
      chk("t7_evdb_vld", evdb_vld, 0);
      chk("t7_drop", drop_cnt, 0);
      chk("t7_errs", {err_conflict, err_ovf, err_opcode}, 0);
      model_reset();
      idle(); rdb_rdy = '1; evdb_rdy = '1;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("t7_empty_after", rdb_vld, 0);
      for (int n = 0; n < 3000; n++) begin
         rand_inputs(1'b1);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
